// File: rtl/mod179_recon.sv
// Rebuilds x = q*MODULUS + r from a quotient/residue pair using a sequential
// shift-add multiplier with a start/done handshake and fixed QW-cycle latency.
module mod179_recon #(
    parameter int MODULUS = 179,
    parameter int QW      = 9,
    parameter int RW      = 8,
    parameter int XW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [QW-1:0] q,
    input  logic [RW-1:0] r,
    input  logic          start,
    output logic          done,
    output logic [XW-1:0] x,
    output logic          ovf,
    output logic          err
);

    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [QW-1:0]   r_qreg;
    logic [XW:0]     r_acc;
    logic [XW:0]     r_mreg;
    logic [CW-1:0]   r_cnt;
    logic            r_err_l;
    logic [XW:0]     w_acc_sum;
    logic            w_last;

    assign w_last    = (r_cnt == CW'(QW - 1));
    assign w_acc_sum = r_qreg[0] ? (r_acc + r_mreg) : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = MUL;
            MUL:     if (w_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        done = (r_state == FIN);
    end

    // Results are captured from the final accumulate so they are valid during FIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_qreg  <= '0;
            r_acc   <= '0;
            r_mreg  <= '0;
            r_cnt   <= '0;
            r_err_l <= 1'b0;
            x       <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_qreg  <= q;
                        r_acc   <= {{(XW + 1 - RW){1'b0}}, r};
                        r_mreg  <= (XW + 1)'(MODULUS);
                        r_cnt   <= '0;
                        r_err_l <= (r >= RW'(MODULUS));
                    end
                end
                MUL: begin
                    r_acc  <= w_acc_sum;
                    r_qreg <= r_qreg >> 1;
                    r_mreg <= r_mreg << 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        x   <= w_acc_sum[XW-1:0];
                        ovf <= w_acc_sum[XW];
                        err <= r_err_l;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod179_recon.sv
// Scoreboard bench for mod179_recon: stimulus pushes model results, a monitor
// pops and checks value, flags and latency on every done pulse.
module tb_mod179_recon;

    localparam int QW  = 9;
    localparam int RW  = 8;
    localparam int XW  = 16;
    localparam int MOD = 179;

    logic          clk = 1'b0;
    logic          reset;
    logic [QW-1:0] q;
    logic [RW-1:0] r;
    logic          start;
    logic          done;
    logic [XW-1:0] x;
    logic          ovf;
    logic          err;

    typedef struct {
        logic [XW-1:0] x;
        logic          ovf;
        logic          err;
        int unsigned   due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    mod179_recon #(.MODULUS(MOD), .QW(QW), .RW(RW), .XW(XW)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q),
        .r     (r),
        .start (start),
        .done  (done),
        .x     (x),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int qv, input int rv);
        exp_t e;
        int   v;
        v     = qv * MOD + rv;
        e.x   = v[XW-1:0];
        e.ovf = (v > 65535);
        e.err = (rv >= MOD);
        e.due = 0;
        return e;
    endfunction

    // Monitor
    logic          prev_done = 1'b0;
    logic          have_last = 1'b0;
    exp_t          last;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (done) begin
                tests++;
                if (prev_done) begin
                    fails++;
                    $display("FAIL done_twice: done high two cycles in a row at cycle %0d", cyc);
                end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done at cycle %0d with no op pending (x=%0d)", cyc, x);
                end else begin
                    e = sb.pop_front();
                    if (x !== e.x || ovf !== e.ovf || err !== e.err) begin
                        fails++;
                        $display("FAIL result: got x=%0d ovf=%0b err=%0b, want x=%0d ovf=%0b err=%0b",
                                 x, ovf, err, e.x, e.ovf, e.err);
                    end
                    tests++;
                    if (cyc !== e.due) begin
                        fails++;
                        $display("FAIL latency: done at cycle %0d, want %0d", cyc, e.due);
                    end
                    last      = e;
                    have_last = 1'b1;
                end
            end else if (prev_done && have_last) begin
                tests++;
                if (x !== last.x || ovf !== last.ovf || err !== last.err) begin
                    fails++;
                    $display("FAIL hold: got x=%0d ovf=%0b err=%0b, want x=%0d ovf=%0b err=%0b",
                             x, ovf, err, last.x, last.ovf, last.err);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic push_exp(input int qv, input int rv);
        exp_t e;
        e     = model(qv, rv);
        e.due = cyc + QW;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), n);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_op(input int qv, input int rv);
        @(negedge clk);
        q     = QW'(qv);
        r     = RW'(rv);
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(qv, rv);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int x0;
        reset = 1'b0;
        q     = '0;
        r     = '0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b0 || x !== '0 || ovf !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: done=%0b x=%0d ovf=%0b err=%0b, want all 0", done, x, ovf, err);
        end
        reset = 1'b1;

        do_op(0, 0);
        do_op(366, 21);
        do_op(366, 22);
        do_op(100, 179);

        for (int i = 0; i < 1000; i++) begin
            x0 = int'($urandom_range(0, 65535));
            do_op(x0 / MOD, x0 % MOD);
        end
        for (int i = 0; i < 200; i++) begin
            do_op(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
        end

        // Start held high: back-to-back ops every QW+2 cycles
        @(negedge clk);
        q     = QW'(77);
        r     = RW'(200);
        start = 1'b1;
        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            if (i % (QW + 2) == 0) push_exp(77, 200);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-operation
        do_op(100, 179);
        @(negedge clk);
        q     = QW'(5);
        r     = RW'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (done !== 1'b0 || x !== '0 || ovf !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: done=%0b x=%0d ovf=%0b err=%0b, want all 0", done, x, ovf, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (QW + 4) @(negedge clk);
        do_op(1, 1);

        // Start during MUL is ignored
        @(negedge clk);
        q     = QW'(3);
        r     = RW'(0);
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(3, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        q     = QW'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q     = '0;
        wait_idle();
        repeat (QW + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
